instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder. Accepts mnemonic-level instruction requests (class plus register and immediate fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word, buffers it in a small FIFO, and writes it sequentially into instruction memory.
- Used by the bench and boot path to load programs into the Pipe_CPU instruction memory.

Parameters:
FIFO_DEPTH, 4, entries in the encoded-word FIFO (power of 2, at least 2)
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after reset or restart

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid and ready are both high
req_class_i  in  4  mnemonic class (see Behaviour)
req_rs_i  in  5  rs field
req_rt_i  in  5  rt field
req_rd_i  in  5  rd field
req_shamt_i  in  5  shift amount
req_imm_i  in  16  immediate or branch offset
end_i  in  1  one-cycle pulse: end of program, flush the FIFO
restart_i  in  1  one-cycle pulse: leave DONE, reload address from BASE_ADDR
mem_we_o  out  1  memory write request
mem_addr_o  out  ADDR_W  word address
mem_data_o  out  32  encoded instruction
mem_ready_i  in  1  memory accepts the write this cycle
busy_o  out  1  state is not DONE, or FIFO is not empty
done_o  out  1  state is DONE
ovf_o  out  1  sticky: address wrapped
illegal_o  out  1  one-cycle illegal-field pulse (optional feature)
count_o  out  ADDR_W+1  words written since reset or restart

Behaviour:
- Class map, as opcode/funct:
  - 0 ADD 0/0x20; 1 SUB 0/0x22; 2 AND 0/0x24; 3 OR 0/0x25; 4 SLT 0/0x2A; 5 SLL 0/0x00 with shamt.
  - 6 ADDI 8; 7 SLTIU 9; 8 ORI 13; 9 LUI 15; 10 LW 35; 11 SW 43.
  - 12 BEQ 4; 13 BNE 5; 14 BLE 6; 15 BLTZ 1.
- Field layout:
  - R-type: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]. shamt is 0 except for SLL.
  - I-type: op, rs, rt, imm[15:0].
- Encoding is combinational. The encoded word is pushed on the handshake edge.
- FIFO:
  - Registered occupancy count.
  - req_ready_o = !full && state==RUN.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- Memory port:
  - mem_we_o = !empty && state!=DONE.
  - mem_data_o = FIFO head; mem_addr_o = address register.
  - A write completes on mem_we_o && mem_ready_i: pop, address+1, count_o+1.
  - Data and address are held stable while mem_ready_i is low.
- FSM:
  - RUN → FLUSH on end_i.
  - FLUSH → DONE when the FIFO is empty and no write is pending. If the FIFO is already empty when end_i arrives, go RUN → DONE next cycle.
  - DONE → RUN on restart_i: address := BASE_ADDR, count_o := 0, ovf_o := 0.
  - A handshake in the same cycle as end_i is accepted and included in the flush.
- Wrap: a write at address 2^ADDR_W-1 makes the next address 0 and sets ovf_o (sticky until restart or reset). Writing continues.
- Reset (at any time, including mid-flush):
  - state=RUN, FIFO emptied, address=BASE_ADDR, count_o=0.
  - mem_we_o=0, ovf_o=0, illegal_o=0, done_o=0, busy_o=0.
  - req_ready_o=1 from the first cycle after reset.
- Latency: with mem_ready_i=1 and an empty FIFO, a word accepted at edge N is written at edge N+1.

Optional Feature:
INSTR_ENC_CHECK_EN
- Defined:
  - LUI with rs!=0, BLTZ with rt!=0, or a register-writing class with destination $0 (rd for R-type, rt for ADDI/SLTIU/ORI/LUI/LW) is illegal.
  - An illegal request is handshaken but not pushed. illegal_o pulses 1 for one cycle.
- Undefined:
  - rs is forced to 0 for LUI and rt is forced to 0 for BLTZ.
  - All requests are pushed; illegal_o is tied 0.

Test Plan:
- Reset, mem_ready_i=1, send ADD rd=3 rs=1 rt=2 → one cycle later mem_we_o=1, addr 0, data 0x00221820; count_o=1.
- Send ADDI rt=1 rs=0 imm=5, LW rt=2 rs=1 imm=4, SW rt=2 rs=1 imm=8 back-to-back → writes at addr 0,1,2 of 0x20010005, 0x8C220004, 0xAC220008 in order.
- Hold mem_ready_i=0, send 5 requests (FIFO_DEPTH=4) → req_ready_o drops after 4 accepts; mem_data_o stays 0x... head stable. Release → all drain in order, including a 5th: BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF.
- Pulse end_i with 2 words queued, mem_ready_i toggling → req_ready_o=0; DONE after the last write; done_o=1, busy_o=0. restart_i → next write at addr 0, count_o=0.
- ADDR_W=2, write 5 words → addresses 0,1,2,3,0; ovf_o=1 after the 4th write completes.
- LUI rt=4 rs=7 imm=0x1234 → without macro 0x3C041234 is written. With INSTR_ENC_CHECK_EN, illegal_o pulses and nothing is written. SLL rd=2 rt=1 shamt=4 → 0x00011100; BLTZ rs=3 imm=2 → 0x04600002.

Source files
------------

// File: rtl/instr_encoder.sv
// Mnemonic-to-MIPS instruction encoder feeding a small FIFO that streams words into instruction memory.
// Optional field checking is enabled with `define INSTR_ENC_CHECK_EN.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_class_i,
    input  logic [4:0]        req_rs_i,
    input  logic [4:0]        req_rt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_shamt_i,
    input  logic [15:0]       req_imm_i,
    input  logic              end_i,
    input  logic              restart_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic              illegal_o,
    output logic [ADDR_W:0]   count_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]       DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;

    logic [31:0]       fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       occ;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              ovf;

    logic [5:0]  op, funct;
    logic [4:0]  rs_f, rt_f, shamt;
    logic        rtype, illegal;
    logic [31:0] word;
    logic        full, empty, hs, push, pop;

    always_comb begin
        op    = 6'd0;
        funct = 6'd0;
        shamt = 5'd0;
        rtype = 1'b0;
        rs_f  = req_rs_i;
        rt_f  = req_rt_i;
        case (req_class_i)
            4'd0:  begin rtype = 1'b1; funct = 6'h20; end
            4'd1:  begin rtype = 1'b1; funct = 6'h22; end
            4'd2:  begin rtype = 1'b1; funct = 6'h24; end
            4'd3:  begin rtype = 1'b1; funct = 6'h25; end
            4'd4:  begin rtype = 1'b1; funct = 6'h2A; end
            4'd5:  begin rtype = 1'b1; funct = 6'h00; shamt = req_shamt_i; end
            4'd6:  op = 6'd8;
            4'd7:  op = 6'd9;
            4'd8:  op = 6'd13;
            4'd9:  op = 6'd15;
            4'd10: op = 6'd35;
            4'd11: op = 6'd43;
            4'd12: op = 6'd4;
            4'd13: op = 6'd5;
            4'd14: op = 6'd6;
            default: op = 6'd1;
        endcase
`ifdef INSTR_ENC_CHECK_EN
        // Writes to $0 and non-zero don't-care register fields are rejected outright.
        illegal = (req_class_i == 4'd9 && req_rs_i != 5'd0)
               || (req_class_i == 4'd15 && req_rt_i != 5'd0)
               || (rtype && req_rd_i == 5'd0)
               || (req_class_i >= 4'd6 && req_class_i <= 4'd10 && req_rt_i == 5'd0);
`else
        illegal = 1'b0;
        if (req_class_i == 4'd9)  rs_f = 5'd0;
        if (req_class_i == 4'd15) rt_f = 5'd0;
`endif
        word = rtype ? {6'd0, rs_f, rt_f, req_rd_i, shamt, funct}
                     : {op, rs_f, rt_f, req_imm_i};
    end

    assign full        = (occ == DEPTH_C);
    assign empty       = (occ == '0);
    assign req_ready_o = !full && state == RUN;
    assign hs          = req_valid_i && req_ready_o;
    assign push        = hs && !illegal;
    // Outputs that could trigger side effects are silenced while reset is held.
    assign mem_we_o    = !rst_i && !empty && state != DONE;
    assign pop         = mem_we_o && mem_ready_i;
    assign mem_data_o  = fifo[rd_ptr];
    assign mem_addr_o  = addr;
    assign count_o     = count;
    assign ovf_o       = ovf;
    assign done_o      = (state == DONE);
    assign busy_o      = !rst_i && (state != DONE || !empty);

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (end_i) state_nx = (empty && !push) ? DONE : FLUSH;
            FLUSH:   if (empty) state_nx = DONE;
            DONE:    if (restart_i) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo[wr_ptr] <= word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            addr   <= BASE_C;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
            if (state == DONE && restart_i) begin
                addr  <= BASE_C;
                count <= '0;
                ovf   <= 1'b0;
            end else if (pop) begin
                addr  <= addr + ADDR_W'(1);
                count <= count + (ADDR_W+1)'(1);
                if (addr == '1) ovf <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    logic illegal_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) illegal_q <= 1'b0;
        else       illegal_q <= hs && illegal;
    end
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized traffic against a queue-based model.
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int BASE  = 0;

    logic          clk = 1'b0, rst = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [3:0]    req_class = '0;
    logic [4:0]    req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
    logic [15:0]   req_imm = '0;
    logic          end_p = 1'b0, restart_p = 1'b0;
    logic          mem_we, mem_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          busy, done, ovf, illegal;
    logic [AW:0]   count;

    instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_class_i(req_class), .req_rs_i(req_rs), .req_rt_i(req_rt),
        .req_rd_i(req_rd), .req_shamt_i(req_shamt), .req_imm_i(req_imm),
        .end_i(end_p), .restart_i(restart_p),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_ready_i(mem_ready),
        .busy_o(busy), .done_o(done), .ovf_o(ovf), .illegal_o(illegal),
        .count_o(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    bit chk_en = 1'b0;

    // Model: 0 = accepting, 1 = flushing, 2 = finished
    logic [31:0] m_q[$];
    int          m_phase = 0, m_addr = BASE, m_count = 0;
    bit          m_ovf = 1'b0, m_ill = 1'b0;
    logic [31:0] log_data[$];
    int          log_addr[$];
    bit          e_ready, e_we, m_hs, m_push, m_pop, m_was_empty, m_bad;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic logic [31:0] model_word(logic [3:0] c, logic [4:0] rs, logic [4:0] rt,
                                               logic [4:0] rd, logic [4:0] sh, logic [15:0] imm);
        int unsigned op_tab[16] = '{0, 0, 0, 0, 0, 0, 8, 9, 13, 15, 35, 43, 4, 5, 6, 1};
        int unsigned fn_tab[6]  = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 0};
        int unsigned r_s = rs, r_t = rt, s = 0;
        if (c < 6) begin
            if (c == 5) s = sh;
            return 32'(r_s * (1 << 21) + r_t * (1 << 16) + rd * (1 << 11) + s * 64 + fn_tab[c]);
        end
        if (c == 9)  r_s = 0;
        if (c == 15) r_t = 0;
        return 32'(op_tab[c] * 32'h0400_0000 + r_s * (1 << 21) + r_t * (1 << 16) + imm);
    endfunction

    function automatic bit model_illegal(logic [3:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
`ifdef INSTR_ENC_CHECK_EN
        return (c == 9 && rs != 0) || (c == 15 && rt != 0) || (c < 6 && rd == 0)
            || (c >= 6 && c <= 10 && rt == 0);
`else
        return (c == 4'hF && rs == 5'd31 && rt == 5'd31 && rd == 5'd31) && 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        e_ready = (m_q.size() < DEPTH) && m_phase == 0;
        e_we    = !rst && m_q.size() != 0 && m_phase != 2;
        if (chk_en) begin
            chk1("req_ready", req_ready, e_ready);
            chk1("mem_we", mem_we, e_we);
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (e_we) chk("mem_data", mem_data, m_q[0]);
            chk1("done", done, m_phase == 2);
            chk1("busy", busy, !rst && (m_phase != 2 || m_q.size() != 0));
            chk1("ovf", ovf, m_ovf);
            chk("count", 32'(count), 32'(m_count));
            chk1("illegal", illegal, m_ill);
        end
        if (mem_we && mem_ready) begin
            log_data.push_back(mem_data);
            log_addr.push_back(int'(mem_addr));
        end
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_addr = BASE; m_count = 0; m_ovf = 0; m_ill = 0;
        end else begin
            m_bad       = model_illegal(req_class, req_rs, req_rt, req_rd);
            m_hs        = req_valid && e_ready;
            m_push      = m_hs && !m_bad;
            m_pop       = e_we && mem_ready;
            m_was_empty = m_q.size() == 0;
            m_ill       = m_hs && m_bad;
            if (m_pop) begin
                void'(m_q.pop_front());
                if (m_addr == (1 << AW) - 1) m_ovf = 1;
                m_addr  = (m_addr + 1) % (1 << AW);
                m_count = (m_count + 1) % (1 << (AW + 1));
            end
            if (m_push) m_q.push_back(model_word(req_class, req_rs, req_rt, req_rd, req_shamt, req_imm));
            case (m_phase)
                0: if (end_p) m_phase = (m_was_empty && !m_push) ? 2 : 1;
                1: if (m_was_empty) m_phase = 2;
                default: if (restart_p) begin
                    m_phase = 0; m_addr = BASE; m_count = 0; m_ovf = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        log_data.delete(); log_addr.delete();
    endtask

    task automatic send(logic [3:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                        logic [4:0] sh, logic [15:0] imm);
        int g = 0;
        req_class = c; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh; req_imm = imm;
        req_valid = 1'b1;
        while (!req_ready && g < 50) begin tick(); g++; end
        if (!req_ready) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic chk_log(string name, int i, logic [31:0] d, int a);
        if (i >= log_data.size()) begin
            n_checks++; n_err++;
            $display("FAIL %s: got %0d writes expected more than %0d", name, log_data.size(), i);
        end else begin
            chk({name, "_data"}, log_data[i], d);
            chk({name, "_addr"}, 32'(log_addr[i]), 32'(a));
        end
    endtask

    initial begin
        int base, g;
        tick();
        chk_en = 1'b1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        chk1("rst_ready", req_ready, 1'b1);

        // single ADD, one-cycle latency
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        chk1("add_we", mem_we, 1'b1);
        chk("add_addr", 32'(mem_addr), 32'd0);
        chk("add_data", mem_data, 32'h0022_1820);
        tick();
        chk("add_count", 32'(count), 32'd1);

        // back-to-back I-type
        do_reset();
        send(4'd6,  5'd0, 5'd1, 5'd0, 5'd0, 16'd5);
        send(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4);
        send(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'd8);
        repeat (3) tick();
        chk_log("addi", 0, 32'h2001_0005, 0);
        chk_log("lw",   1, 32'h8C22_0004, 1);
        chk_log("sw",   2, 32'hAC22_0008, 2);

        // backpressure: FIFO fills, head held stable
        do_reset();
        mem_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        send(4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0);
        send(4'd2, 5'd7, 5'd8, 5'd9, 5'd0, 16'd0);
        send(4'd3, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0);
        chk1("full_ready", req_ready, 1'b0);
        repeat (3) tick();
        chk("held_data", mem_data, 32'h0022_1820);
        chk("held_addr", 32'(mem_addr), 32'd0);
        mem_ready = 1'b1;
        send(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
        repeat (6) tick();
        chk_log("bp_first", 0, 32'h0022_1820, 0);
        chk_log("bp_beq",   4, 32'h1022_FFFF, 4);

        // flush with toggling memory ready, then restart
        do_reset();
        mem_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        send(4'd3, 5'd2, 5'd3, 5'd4, 5'd0, 16'd0);
        end_p = 1'b1; tick(); end_p = 1'b0;
        chk1("flush_ready", req_ready, 1'b0);
        g = 0;
        while (!done && g < 40) begin mem_ready = g[0]; tick(); g++; end
        chk1("flush_done", done, 1'b1);
        chk1("flush_busy", busy, 1'b0);
        chk("flush_writes", 32'(log_data.size()), 32'd2);
        mem_ready = 1'b1;
        restart_p = 1'b1; tick(); restart_p = 1'b0;
        chk1("restart_done", done, 1'b0);
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_addr", 32'(mem_addr), 32'd0);
        end_p = 1'b1; tick(); end_p = 1'b0;
        chk1("empty_end_done", done, 1'b1);
        restart_p = 1'b1; tick(); restart_p = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        tick();
        chk_log("after_restart", 2, 32'h0022_1820, 0);

        // address wrap
        do_reset();
        for (int i = 0; i < 7; i++) send(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i));
        tick();
        chk1("pre_wrap_ovf", ovf, 1'b0);
        send(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'd7);
        tick();
        chk1("wrap_ovf", ovf, 1'b1);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        chk("wrap_count", 32'(count), 32'd8);
        send(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'd8);
        tick();
        chk_log("wrapped", 8, 32'h2001_0008, 0);

        // forced/illegal fields, SLL, BLTZ
        do_reset();
        send(4'd9, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234);
`ifdef INSTR_ENC_CHECK_EN
        chk1("lui_illegal", illegal, 1'b1);
        tick();
        chk("lui_dropped", 32'(log_data.size()), 32'd0);
        base = 0;
`else
        tick();
        chk_log("lui", 0, 32'h3C04_1234, 0);
        base = 1;
`endif
        send(4'd5, 5'd0, 5'd1, 5'd2, 5'd4, 16'd0);
        send(4'd15, 5'd3, 5'd0, 5'd0, 5'd0, 16'd2);
        repeat (2) tick();
        chk_log("sll",  base,     32'h0001_1100, base);
        chk_log("bltz", base + 1, 32'h0460_0002, base + 1);

        // randomized traffic, model-checked every cycle
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_class = 4'($urandom);
            req_rs    = 5'($urandom);
            req_rt    = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            req_rd    = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            req_shamt = 5'($urandom);
            req_imm   = 16'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            end_p     = ($urandom_range(0, 49) == 0);
            restart_p = done && ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        req_valid = 1'b0; end_p = 1'b0; restart_p = 1'b0; rst = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
